flash_rx_packer: RTL and testbench
==================================

# flash_rx_packer

Downstream consumer of the SPI flash read path. Takes the byte stream produced by the SPI engine (`mydata_o` / `myvalid_o`) and packs it big-endian into 32-bit words. Words are buffered in a small show-ahead FIFO and delivered over a valid/ready interface. A flush input, driven by the command `Done_Sig`, emits any trailing partial word at the end of a read command.

## Interface
- `DEPTH`, 4: FIFO depth in words; power of two, ≥2.
- `LW`, 3: width of `level_o`; must equal log2(DEPTH)+1.

Ports (all in the `CLK` domain):
- `CLK`  in  1  system clock.
- `RST`  in  1  reset; synchronous, active-high.
- `byte_i`  in  8  read byte; connects to `mydata_o`.
- `byte_valid_i`  in  1  one-cycle strobe per byte; connects to `myvalid_o`.
- `flush_i`  in  1  one-cycle pulse at end of command; connects to `Done_Sig`.
- `clr_i`  in  1  synchronous clear of the packer, FIFO and overflow flag.
- `word_o`  out  32  head-of-FIFO word. First received byte is in [31:24].
- `word_bytes_o`  out  3  number of valid bytes in `word_o` (1..4); 0 when empty.
- `word_valid_o`  out  1  FIFO is not empty.
- `word_ready_i`  in  1  consumer accepts `word_o` when both valid and ready are high.
- `level_o`  out  LW  number of words stored (0..DEPTH).
- `overflow_o`  out  1  sticky; set when a word is dropped because the FIFO is full.

## Operation
- **Packer state**
  - `acc[23:0]` holds up to three pending bytes.
  - `cnt[1:0]` counts pending bytes (0..3).
- **Byte accepted** (`byte_valid_i` = 1):
  - If `cnt` < 3: shift `byte_i` into `acc`, then `cnt` += 1.
  - If `cnt` = 3: push `{acc, byte_i}` with bytes = 4, then set `cnt` to 0.
- **Flush** (`flush_i` = 1):
  - If `cnt` > 0: push the pending bytes left-justified, unused low bytes zero, bytes = `cnt`. Then set `cnt` to 0.
  - If `cnt` = 0: no push.
- **Byte and flush in the same cycle**
  - The byte is appended first, then the flush is evaluated.
  - Exactly one push occurs, with bytes = `cnt`+1, capped at 4. If that byte completes a word, the push carries 4 bytes and nothing else happens.
  - At most one push occurs per cycle.
- **FIFO**
  - DEPTH entries, each 35 bits: the word plus a 3-bit byte count.
  - Write and read pointers wrap modulo DEPTH.
  - Full when `level` = DEPTH; empty when `level` = 0.
- **Pop**: happens when `word_valid_o` && `word_ready_i`.
- **Push when full**
  - If a pop occurs in the same cycle: the push is accepted and the level is unchanged.
  - Otherwise: the word is dropped, `overflow_o` ← 1, and `cnt` still clears.
- **Pop when empty**: ignored; no pointer movement.
- **Show-ahead output**
  - `word_o` and `word_bytes_o` reflect the head entry combinationally.
  - Both are forced to 0 while the FIFO is empty.
- **Priority**: `RST` > `clr_i` > normal operation.
  - `clr_i` discards pending bytes and stored words and clears `overflow_o`.
  - A byte, flush or pop in the same cycle as `clr_i` is ignored.
- `overflow_o` clears only on `RST` or `clr_i`.

## Timing
- **Reset values** (`RST` sampled high at a `CLK` edge):
  - Outputs: `word_o` = 0, `word_bytes_o` = 0, `word_valid_o` = 0, `level_o` = 0, `overflow_o` = 0.
  - Internal state: `cnt` = 0, both pointers = 0.
- **Reset mid-stream**: pending bytes and buffered words are lost. No partial push occurs.
- **Latency**
  - The byte (or flush) that triggers a push is sampled at edge N.
  - `word_valid_o` and `word_o` are valid after edge N; `level_o` increments after edge N.
- **Pop timing**: a pop sampled at edge N updates the head, `level_o` and `word_valid_o` after edge N.
- **Throughput**
  - Input sustains one byte per cycle.
  - Output sustains one word per cycle with `word_ready_i` held high.
- **Byte spacing**: `byte_valid_i` may assert on any cycle, including back-to-back. There is no ready back to the SPI engine; excess data is dropped and flagged.
- **Logic structure**: no combinational path from inputs to `word_valid_o`. `word_ready_i` affects only next-state logic.

## Test plan
- **Full word**
  - Stimulus: bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles, `word_ready_i` = 0.
  - Response: one cycle after the 4th byte, `word_o` = 0x11223344, `word_bytes_o` = 4, `level_o` = 1.
- **Partial flush**
  - Stimulus: bytes 0xA1, 0xB2, then `flush_i` two cycles later.
  - Response: `word_o` = 0xA1B20000, `word_bytes_o` = 2.
  - Follow-up: a second flush with `cnt` = 0 produces no push.
- **Simultaneous byte and flush**
  - Case 1: 0x01, then 0x02 together with `flush_i`. Response: a single word 0x01020000, bytes = 2.
  - Case 2: repeat with the 4th byte 0x04 arriving together with the flush. Response: a single word 0x01020304, bytes = 4.
- **Overflow and simultaneous pop**
  - Stimulus: push DEPTH+1 words (ready = 0).
  - Response: `level_o` = DEPTH, `overflow_o` = 1, and the first DEPTH words are drained intact in order.
  - Second stimulus: refill to DEPTH, then with ready = 1 present a word-completing byte.
  - Response: the push is accepted, `level_o` stays at DEPTH, and `overflow_o` is unchanged.
- **Pointer wrap**
  - Stimulus: stream 64 bytes of incrementing values with ready toggling 1/0.
  - Response: 16 words in order, e.g. 0x00010203 … 0x3C3D3E3F, with no loss.
- **Reset and clear mid-stream**
  - Stimulus: 2 bytes plus 2 stored words, then `RST` for one cycle.
  - Response: all outputs at reset values. A following flush yields no word.
  - Repeat with `clr_i` after an overflow: response is the same, and `overflow_o` = 0.

Source files
------------

// File: rtl/flash_rx_packer.sv
// Packs the SPI flash read byte stream big-endian into 32-bit words and buffers
// them in a show-ahead FIFO with a valid/ready output and sticky overflow flag.
module flash_rx_packer #(
    parameter int DEPTH = 4,
    parameter int LW    = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [7:0]    byte_i,
    input  logic          byte_valid_i,
    input  logic          flush_i,
    input  logic          clr_i,
    output logic [31:0]   word_o,
    output logic [2:0]    word_bytes_o,
    output logic          word_valid_o,
    input  logic          word_ready_i,
    output logic [LW-1:0] level_o,
    output logic          overflow_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pending bytes sit in the low end of the accumulator; this moves them to the top.
    function automatic logic [31:0] left_justify(input logic [23:0] v, input logic [2:0] n);
        logic [31:0] r;
        case (n)
            3'd1:    r = {v[7:0], 24'h000000};
            3'd2:    r = {v[15:0], 16'h0000};
            3'd3:    r = {v[23:0], 8'h00};
            default: r = 32'h00000000;
        endcase
        return r;
    endfunction

    logic [23:0]   acc_r;
    logic [1:0]    cnt_r;
    logic [34:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          overflow_r;

    logic [23:0]   acc_nxt_s;
    logic [1:0]    cnt_nxt_s;
    logic [23:0]   appended_s;
    logic          push_s;
    logic [31:0]   push_word_s;
    logic [2:0]    push_bytes_s;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          wr_en_s;
    logic          drop_s;
    logic [34:0]   head_s;

    // Packer next state: append byte first, then evaluate flush; at most one push.
    always_comb begin
        acc_nxt_s    = acc_r;
        cnt_nxt_s    = cnt_r;
        push_s       = 1'b0;
        push_word_s  = 32'h00000000;
        push_bytes_s = 3'd0;
        appended_s   = {acc_r[15:0], byte_i};
        if (byte_valid_i) begin
            if (cnt_r == 2'd3) begin
                push_s       = 1'b1;
                push_word_s  = {acc_r, byte_i};
                push_bytes_s = 3'd4;
                cnt_nxt_s    = 2'd0;
            end else if (flush_i) begin
                push_s       = 1'b1;
                push_bytes_s = {1'b0, cnt_r} + 3'd1;
                push_word_s  = left_justify(appended_s, push_bytes_s);
                cnt_nxt_s    = 2'd0;
            end else begin
                acc_nxt_s    = appended_s;
                cnt_nxt_s    = cnt_r + 2'd1;
            end
        end else if (flush_i && (cnt_r != 2'd0)) begin
            push_s       = 1'b1;
            push_bytes_s = {1'b0, cnt_r};
            push_word_s  = left_justify(acc_r, push_bytes_s);
            cnt_nxt_s    = 2'd0;
        end else begin
            cnt_nxt_s    = cnt_r;
        end
    end

    assign empty_s = (level_r == {LW{1'b0}});
    assign full_s  = (level_r == LW'(DEPTH));
    assign pop_s   = !empty_s && word_ready_i;
    assign wr_en_s = push_s && (!full_s || pop_s);
    assign drop_s  = push_s && full_s && !pop_s;

    // Packer, pointer, level and overflow registers.
    always_ff @(posedge CLK) begin
        if (RST || clr_i) begin
            acc_r      <= 24'h000000;
            cnt_r      <= 2'd0;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= {LW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_nxt_s;
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care until written since empty forces outputs to zero.
    always_ff @(posedge CLK) begin
        if (!RST && !clr_i && wr_en_s) begin
            mem_r[wr_ptr_r] <= {push_bytes_s, push_word_s};
        end
    end

    assign head_s       = mem_r[rd_ptr_r];
    assign word_o       = empty_s ? 32'h00000000 : head_s[31:0];
    assign word_bytes_o = empty_s ? 3'd0 : head_s[34:32];
    assign word_valid_o = !empty_s;
    assign level_o      = level_r;
    assign overflow_o   = overflow_r;

endmodule

// File: tb/tb_flash_rx_packer.sv
// Directed self-checking bench for flash_rx_packer.
module tb_flash_rx_packer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        clr_i = 1'b0;
    logic [31:0] word_o;
    logic [2:0]  word_bytes_o;
    logic        word_valid_o;
    logic        word_ready_i = 1'b0;
    logic [2:0]  level_o;
    logic        overflow_o;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_idx = 0;

    flash_rx_packer #(.DEPTH(4), .LW(3)) dut (
        .CLK(CLK), .RST(RST), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
        .flush_i(flush_i), .clr_i(clr_i), .word_o(word_o), .word_bytes_o(word_bytes_o),
        .word_valid_o(word_valid_o), .word_ready_i(word_ready_i), .level_o(level_o),
        .overflow_o(overflow_o)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input int n);
        return {8'(4*n), 8'(4*n+1), 8'(4*n+2), 8'(4*n+3)};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        byte_i = b;
        byte_valid_i = 1'b1;
        tick();
        byte_valid_i = 1'b0;
    endtask

    task automatic push_word(input int n);
        for (int j = 0; j < 4; j++) send_byte(8'(4*n+j));
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] w, input logic [2:0] b);
        check({tag, "_valid"}, {31'd0, word_valid_o}, 32'd1);
        check({tag, "_word"}, word_o, w);
        check({tag, "_bytes"}, {29'd0, word_bytes_o}, {29'd0, b});
        word_ready_i = 1'b1;
        tick();
        word_ready_i = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_word"}, word_o, 32'h0);
        check({tag, "_bytes"}, {29'd0, word_bytes_o}, 32'd0);
        check({tag, "_valid"}, {31'd0, word_valid_o}, 32'd0);
        check({tag, "_level"}, {29'd0, level_o}, 32'd0);
        check({tag, "_ovf"}, {31'd0, overflow_o}, 32'd0);
    endtask

    initial begin
        tick();
        tick();
        RST = 1'b0;
        check_idle("reset");

        // Full word
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        check("full_not_yet", {31'd0, word_valid_o}, 32'd0);
        send_byte(8'h44);
        check("full_level", {29'd0, level_o}, 32'd1);
        pop_check("full", 32'h11223344, 3'd4);
        check("full_drained", {29'd0, level_o}, 32'd0);

        // Partial flush, then flush with nothing pending
        send_byte(8'hA1); send_byte(8'hB2);
        tick();
        do_flush();
        check("pflush_level", {29'd0, level_o}, 32'd1);
        do_flush();
        check("pflush_second_none", {29'd0, level_o}, 32'd1);
        pop_check("pflush", 32'hA1B20000, 3'd2);

        // Byte together with flush
        send_byte(8'h01);
        flush_i = 1'b1; send_byte(8'h02); flush_i = 1'b0;
        check("sim1_level", {29'd0, level_o}, 32'd1);
        pop_check("sim1", 32'h01020000, 3'd2);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        flush_i = 1'b1; send_byte(8'h04); flush_i = 1'b0;
        check("sim2_level", {29'd0, level_o}, 32'd1);
        pop_check("sim2", 32'h01020304, 3'd4);
        do_flush();
        check("sim2_no_extra", {29'd0, level_o}, 32'd0);

        // Overflow: five words into a four-deep FIFO
        for (int k = 0; k < 5; k++) push_word(16 + k);
        check("ovf_level", {29'd0, level_o}, 32'd4);
        check("ovf_flag", {31'd0, overflow_o}, 32'd1);
        for (int k = 0; k < 4; k++) pop_check("ovf_drain", exp_word(16 + k), 3'd4);
        check("ovf_empty", {29'd0, level_o}, 32'd0);
        check("ovf_sticky", {31'd0, overflow_o}, 32'd1);

        // Push into full FIFO while popping
        clr_i = 1'b1; tick(); clr_i = 1'b0;
        for (int k = 0; k < 4; k++) push_word(20 + k);
        send_byte(8'(4*24)); send_byte(8'(4*24+1)); send_byte(8'(4*24+2));
        word_ready_i = 1'b1;
        send_byte(8'(4*24+3));
        word_ready_i = 1'b0;
        check("fullpop_level", {29'd0, level_o}, 32'd4);
        check("fullpop_ovf", {31'd0, overflow_o}, 32'd0);
        for (int k = 1; k < 5; k++) pop_check("fullpop_drain", exp_word(20 + k), 3'd4);

        // Pointer wrap with ready toggling
        exp_idx = 0;
        for (int i = 0; i < 64; i++) begin
            byte_i = 8'(i);
            byte_valid_i = 1'b1;
            word_ready_i = (i % 2 == 0);
            if (word_valid_o && word_ready_i) begin
                check("wrap_word", word_o, exp_word(exp_idx));
                exp_idx++;
            end
            tick();
        end
        byte_valid_i = 1'b0;
        word_ready_i = 1'b1;
        for (int k = 0; k < 40 && word_valid_o; k++) begin
            check("wrap_word", word_o, exp_word(exp_idx));
            exp_idx++;
            tick();
        end
        word_ready_i = 1'b0;
        check("wrap_count", 32'(exp_idx), 32'd16);
        check("wrap_ovf", {31'd0, overflow_o}, 32'd0);

        // Reset mid-stream
        push_word(30); push_word(31);
        send_byte(8'hC1); send_byte(8'hC2);
        check("rst_pre_level", {29'd0, level_o}, 32'd2);
        RST = 1'b1; tick(); RST = 1'b0;
        check_idle("rst_mid");
        do_flush();
        check("rst_flush_none", {29'd0, level_o}, 32'd0);

        // Clear after overflow, with a byte in the same cycle ignored
        for (int k = 0; k < 5; k++) push_word(40 + k);
        send_byte(8'hD1); send_byte(8'hD2);
        check("clr_pre_ovf", {31'd0, overflow_o}, 32'd1);
        clr_i = 1'b1; send_byte(8'hD3); clr_i = 1'b0;
        check_idle("clr_mid");
        do_flush();
        check("clr_flush_none", {29'd0, level_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
